data_upload: RTL and testbench

// - Other direction of the io-controller file interface: streams a core-RAM region out to the io controller over SPI (save/tape-out).
// - SPI slave, mode 0, sampled in the core clock domain; shares sck/ss/sdi with the download path, drives sdo.
// - Core supplies base address and length. The block prefetches bytes from RAM through a simple read port and shifts them out MSB first.

---
 rtl/data_upload.sv | 210 +++++++++++++++++++++
 tb/tb_data_upload.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_upload.sv
// SPI-slave upload path: streams a core-RAM region to the io controller on sdo.
// SPI pins are synchronised into clk; RAM bytes are prefetched one ahead of the shifter.
module data_upload #(
  parameter int ADDR_W     = 25,
  parameter int LEN_W      = 24,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              sdi,
  output logic              sdo,
  input  logic [ADDR_W-1:0] upload_addr,
  input  logic [LEN_W-1:0]  upload_len,
  output logic              uploading,
  output logic              done,
  output logic              rd,
  output logic [ADDR_W-1:0] a,
  input  logic [7:0]        q
);

  // state    | meaning
  // PF_IDLE  | no fetch in flight, buffer not valid
  // PF_REQ   | rd strobe out, a = ptr
  // PF_WAIT  | counting RD_LATENCY down to capture of q
  // PF_READY | buffer holds RAM[ptr] until the slot completes
  typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT, PF_READY} pf_state_e;

  localparam logic [7:0] CMD_RX     = 8'h56;
  localparam logic [7:0] CMD_RX_DAT = 8'h57;
  localparam logic [7:0] CMD_RX_LEN = 8'h58;
  localparam logic [2:0] LAT_INIT   = 3'(RD_LATENCY - 1);

  logic [2:0]        sck_sync_q;
  logic [1:0]        ss_sync_q, sdi_sync_q;
  logic [3:0]        cnt_q;
  logic [6:0]        sh_in_q;
  logic [7:0]        cmd_q, shreg_q, buf_q;
  logic              sdo_q, uploading_q, done_q, rd_q, load_pend_q, pf_queued_q;
  logic [LEN_W-1:0]  len_q, len_sh_q, rem_q;
  logic [ADDR_W-1:0] ptr_q, a_q;
  logic [2:0]        lat_q;
  pf_state_e         pf_state_q;

  logic              ss_s, sdi_s, sck_rise, sck_fall;
  logic [7:0]        byte_in, slot_cmd;
  logic              at_cmd_end, at_slot_end, load_ev, dat_load, len_load;
  logic              begin_ev, end_ev, advance_ev, pf_req, pf_capture;
  logic [LEN_W-1:0]  rem_dec_d;
  logic [ADDR_W-1:0] ptr_inc_d, pf_addr_d;

  assign ss_s     = ss_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign sck_rise = ~ss_s & sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~ss_s & ~sck_sync_q[1] & sck_sync_q[2];
  assign byte_in  = {sh_in_q, sdi_s};

  assign at_cmd_end  = sck_rise && (cnt_q == 4'd7);
  assign at_slot_end = sck_rise && (cnt_q == 4'd15);
  assign slot_cmd    = at_cmd_end ? byte_in : cmd_q;
  assign load_ev     = at_cmd_end | at_slot_end;
  assign dat_load    = load_ev && (slot_cmd == CMD_RX_DAT);
  assign len_load    = load_ev && (slot_cmd == CMD_RX_LEN);

  assign begin_ev   = at_slot_end && (cmd_q == CMD_RX) && sdi_s;
  assign end_ev     = at_slot_end && (cmd_q == CMD_RX) && !sdi_s;
  assign advance_ev = at_slot_end && (cmd_q == CMD_RX_DAT) && uploading_q && (rem_q != '0);
  assign rem_dec_d  = rem_q - LEN_W'(1);
  assign ptr_inc_d  = ptr_q + ADDR_W'(1);
  assign pf_req     = begin_ev | (advance_ev && (rem_dec_d != '0));
  assign pf_addr_d  = begin_ev ? upload_addr : ptr_inc_d;
  assign pf_capture = (pf_state_q == PF_WAIT) && (lat_q == 3'd0);

  assign sdo       = sdo_q;
  assign uploading = uploading_q;
  assign done      = done_q;
  assign rd        = rd_q;
  assign a         = a_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= 2'b11;
      sdi_sync_q  <= '0;
      cnt_q       <= '0;
      sh_in_q     <= '0;
      cmd_q       <= '0;
      shreg_q     <= '0;
      buf_q       <= '0;
      sdo_q       <= 1'b0;
      uploading_q <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      load_pend_q <= 1'b0;
      pf_queued_q <= 1'b0;
      len_q       <= '0;
      len_sh_q    <= '0;
      rem_q       <= '0;
      ptr_q       <= '0;
      a_q         <= '0;
      lat_q       <= '0;
      pf_state_q  <= PF_IDLE;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck};
      ss_sync_q  <= {ss_sync_q[0], ss};
      sdi_sync_q <= {sdi_sync_q[0], sdi};
      rd_q       <= 1'b0;
      done_q     <= 1'b0;

      if (ss_s) begin
        cnt_q       <= '0;
        sdo_q       <= 1'b0;
        load_pend_q <= 1'b0;
      end else begin
        if (sck_rise) begin
          sh_in_q <= byte_in[6:0];
          cnt_q   <= (cnt_q == 4'd15) ? 4'd8 : cnt_q + 4'd1;
          if (cnt_q == 4'd7) cmd_q <= byte_in;
        end
        if (sck_fall) begin
          if (cnt_q[3] && (cmd_q == CMD_RX_DAT || cmd_q == CMD_RX_LEN)) begin
            sdo_q   <= shreg_q[7];
            shreg_q <= {shreg_q[6:0], 1'b0};
          end else begin
            sdo_q <= 1'b0;
          end
        end
        // Data slots load once the byte at ptr is in hand; the fetch fits inside half an sck period.
        if (load_pend_q) begin
          if (!uploading_q || rem_q == '0) begin
            shreg_q     <= '0;
            load_pend_q <= 1'b0;
          end else if (pf_state_q == PF_READY) begin
            shreg_q     <= buf_q;
            load_pend_q <= 1'b0;
          end else if (pf_capture && !pf_queued_q) begin
            shreg_q     <= q;
            load_pend_q <= 1'b0;
          end
        end
        if (dat_load) load_pend_q <= 1'b1;
        if (len_load) begin
          if (at_cmd_end) begin
            shreg_q  <= len_q[7:0];
            len_sh_q <= len_q >> 8;
          end else begin
            shreg_q  <= len_sh_q[7:0];
            len_sh_q <= len_sh_q >> 8;
          end
        end
      end

      if (begin_ev) begin
        ptr_q       <= upload_addr;
        rem_q       <= upload_len;
        len_q       <= upload_len;
        uploading_q <= 1'b1;
      end
      if (end_ev) begin
        uploading_q <= 1'b0;
        done_q      <= 1'b1;
      end
      if (advance_ev) begin
        ptr_q <= ptr_inc_d;
        rem_q <= rem_dec_d;
      end

      if (end_ev) begin
        pf_state_q  <= PF_IDLE;
        pf_queued_q <= 1'b0;
      end else begin
        case (pf_state_q)
          PF_IDLE, PF_READY: begin
            if (pf_req) begin
              pf_state_q <= PF_REQ;
              rd_q       <= 1'b1;
              a_q        <= pf_addr_d;
            end else if (advance_ev) begin
              pf_state_q <= PF_IDLE;
            end
          end
          PF_REQ: begin
            pf_state_q <= PF_WAIT;
            lat_q      <= LAT_INIT;
            if (pf_req) pf_queued_q <= 1'b1;
          end
          PF_WAIT: begin
            if (lat_q == 3'd0) begin
              buf_q <= q;
              if (pf_queued_q || pf_req) begin
                pf_state_q  <= PF_REQ;
                rd_q        <= 1'b1;
                a_q         <= pf_req ? pf_addr_d : ptr_q;
                pf_queued_q <= 1'b0;
              end else begin
                pf_state_q <= PF_READY;
              end
            end else begin
              lat_q <= lat_q - 3'd1;
              if (pf_req) pf_queued_q <= 1'b1;
            end
          end
          default: pf_state_q <= PF_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: SPI master tasks, latency-2 RAM model, hand-computed bytes.
`timescale 1ns/1ps
module tb_data_upload;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0, ss = 1'b1, sdi = 1'b0;
  logic        sdo;
  logic [24:0] upload_addr;
  logic [23:0] upload_len;
  logic        uploading, done, rd;
  logic [24:0] a;
  logic [7:0]  q;

  logic [7:0]  mem [0:1023];
  logic [7:0]  ram_d1;
  logic [24:0] rd_log [$];
  int          rd_total = 0, done_total = 0;
  logic [7:0]  rx_bytes [8];
  int          n_checks = 0, n_fail = 0;
  int          rd_base, done_base;
  logic [7:0]  r;
  logic [7:0]  exp_stream [4];

  data_upload dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi), .sdo(sdo),
    .upload_addr(upload_addr), .upload_len(upload_len),
    .uploading(uploading), .done(done), .rd(rd), .a(a), .q(q)
  );

  always #5 clk = ~clk;

  // q valid two clks after the clk that samples rd
  always @(posedge clk) begin
    ram_d1 <= rd ? mem[a[9:0]] : 8'hEE;
    q      <= ram_d1;
  end

  always @(negedge clk) begin
    if (rd) begin
      rd_total++;
      rd_log.push_back(a);
    end
    if (done) done_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      sdi = tx[7-i];
      #HALF;
      sck = 1'b1;
      rx  = {rx[6:0], sdo};
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input int nslot, input logic [7:0] dat,
                          input int last_bits);
    logic [7:0] rb;
    ss = 1'b0;
    #(2*HALF);
    spi_bits(cmd, 8, rb);
    for (int s = 0; s < nslot; s++) begin
      spi_bits(dat, (s == nslot - 1) ? last_bits : 8, rb);
      rx_bytes[s] = rb;
    end
    sdi = 1'b0;
    #HALF;
    ss = 1'b1;
    #(4*HALF);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[10'h100] = 8'hA5;
    mem[10'h101] = 8'h3C;
    mem[10'h102] = 8'hFF;
    exp_stream[0] = 8'hA5; exp_stream[1] = 8'h3C; exp_stream[2] = 8'hFF; exp_stream[3] = 8'h00;
    upload_addr = '0;
    upload_len  = '0;

    #12;
    check("rst_sdo", sdo, 0);
    check("rst_rd", rd, 0);
    check("rst_uploading", uploading, 0);
    check("rst_a", a, 0);
    check("rst_done", done, 0);
    #20 reset_n = 1'b1;
    #40;

    spi_xfer(8'h57, 2, 8'h00, 8);
    check("idle_dat_slot0", rx_bytes[0], 8'h00);
    check("idle_dat_slot1", rx_bytes[1], 8'h00);

    upload_addr = 25'h000100;
    upload_len  = 24'd3;
    rd_base = rd_total;
    spi_xfer(8'h56, 1, 8'h01, 8);
    check("begin_uploading", uploading, 1);
    check("begin_rd_count", rd_total - rd_base, 1);
    if (rd_log.size() > rd_base) check("begin_rd_addr", rd_log[rd_base], 25'h000100);
    upload_addr = 25'h0003FF;
    upload_len  = 24'd7;

    rd_base = rd_total;
    spi_xfer(8'h57, 1, 8'h00, 3);
    check("abort_partial_bits", rx_bytes[0], 8'h05);
    check("abort_no_rd", rd_total - rd_base, 0);

    rd_base = rd_total;
    spi_xfer(8'h57, 4, 8'h00, 8);
    for (int i = 0; i < 4; i++) check($sformatf("stream_byte%0d", i), rx_bytes[i], exp_stream[i]);
    check("stream_rd_count", rd_total - rd_base, 2);
    if (rd_log.size() > rd_base + 1) begin
      check("stream_rd_addr0", rd_log[rd_base], 25'h000101);
      check("stream_rd_addr1", rd_log[rd_base+1], 25'h000102);
    end

    upload_addr = 25'h000200;
    upload_len  = 24'h000203;
    spi_xfer(8'h56, 1, 8'h01, 8);
    spi_xfer(8'h58, 4, 8'h00, 8);
    check("len_byte0", rx_bytes[0], 8'h03);
    check("len_byte1", rx_bytes[1], 8'h02);
    check("len_byte2", rx_bytes[2], 8'h00);
    check("len_byte3", rx_bytes[3], 8'h00);

    done_base = done_total;
    spi_xfer(8'h56, 1, 8'h00, 8);
    check("end_uploading", uploading, 0);
    check("end_done_clks", done_total - done_base, 1);
    spi_xfer(8'h57, 1, 8'h00, 8);
    check("end_dat_slot", rx_bytes[0], 8'h00);

    upload_addr = 25'h000100;
    upload_len  = 24'd3;
    spi_xfer(8'h56, 1, 8'h01, 8);
    ss = 1'b0;
    #(2*HALF);
    spi_bits(8'h57, 8, r);
    spi_bits(8'h00, 4, r);
    check("pre_reset_uploading", uploading, 1);
    check("pre_reset_a", a, 25'h000100);
    reset_n = 1'b0;
    #20;
    check("midrst_sdo", sdo, 0);
    check("midrst_rd", rd, 0);
    check("midrst_uploading", uploading, 0);
    check("midrst_a", a, 0);
    check("midrst_done", done, 0);
    reset_n = 1'b1;
    #20;
    ss = 1'b1;
    #(4*HALF);
    spi_xfer(8'h57, 2, 8'h00, 8);
    check("post_rst_slot0", rx_bytes[0], 8'h00);
    check("post_rst_slot1", rx_bytes[1], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
